alu_operand_fetch: RTL
======================

# alu_operand_fetch

Operand-fetch / issue stage that sits directly upstream of the 4-bit ALU. It holds a 4-entry register file and accepts packed instructions over a valid/ready handshake. It reads both source operands, tracks outstanding destinations with a scoreboard, and presents a registered operand bundle (a, b, op, rd) to the ALU side. ALU results return through a writeback port that updates the register file and clears the scoreboard.

## Interface
Parameters:
- DW, 4, operand and register width; must match ALU width.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  instruction present.
- in_ready  output  1  stage accepts instruction this cycle.
- in_instr  input  8  packed instruction: [7:6] op, [5:4] rd, [3:2] rs1, [1:0] rs2.
- out_valid  output  1  operand bundle valid toward ALU.
- out_ready  input  1  downstream accepts bundle.
- out_a  output  DW  operand from R[rs1].
- out_b  output  DW  operand from R[rs2].
- out_op  output  2  ALU op: 00 add, 01 sub, 10 and, 11 or.
- out_rd  output  2  destination index carried to writeback.
- wb_en  input  1  writeback strobe.
- wb_rd  input  2  writeback destination index.
- wb_data  input  DW  writeback value (ALU result).

## Operation
- Register file R[0..3], DW bits each. Only writeback writes it: R[wb_rd] <= wb_data when wb_en.
- Scoreboard pend[3:0]: pend[rd] set on accept; pend[wb_rd] cleared on wb_en. If set and clear hit the same index in the same cycle, set wins.
- Hazard: rs1 or rs2 has pend set and is not resolved by bypass (see Configuration). rd is not checked; WAW is allowed, and the first writeback clears the bit.
- in_ready = (!out_valid | out_ready) & !hazard. It depends combinationally on in_instr and wb_* when in_valid.
- Accept = in_valid & in_ready. On accept, the output register loads a, b, op and rd, and out_valid goes to 1.
- If out_valid & out_ready and there is no accept, out_valid goes to 0.
- While out_valid & !out_ready, the output bundle holds stable.
- rs1 == rs2 is legal; both operands read the same register.

## Timing
- Reset values: R[i] = i (zero-extended to DW), pend = 0, out_valid = 0, out_a = out_b = 0, out_op = 0, out_rd = 0.
- in_ready is 1 after reset when out_ready is 1 or out_valid is 0.
- Latency: an instruction accepted in cycle N is presented with out_valid = 1 in cycle N+1.
- Throughput is one instruction per cycle when there is no hazard and out_ready is held at 1.
- Writeback takes effect at the edge: the register value and the pend clear are visible from cycle N+1 for a wb_en in cycle N.
- Reset asserted mid-operation immediately clears out_valid, pend and the register file to their reset values. Any in-flight bundle is dropped.

## Configuration
- ALU_OPF_BYPASS_EN defined:
  - A source matching wb_rd while wb_en is high is not a hazard.
  - That operand takes wb_data in the same cycle.
  - A back-to-back dependent instruction issues in the same cycle as the writeback.
- ALU_OPF_BYPASS_EN undefined:
  - Hazard is pend[rs] only, using the registered value.
  - A dependent instruction stalls through the writeback cycle and issues the cycle after, reading the updated R.

## Test plan
- Reset, then issue op=00 rd=0 rs1=2 rs2=3 -> next cycle out_valid=1, out_a=2, out_b=3, out_op=00, out_rd=0; pend[0]=1.
- Issue rd=1 rs1=2 rs2=3, then immediately an instruction with rs1=1 -> in_ready=0 until writeback. Then apply wb_en=1, wb_rd=1, wb_data=5:
  - With the macro: accepted in the wb cycle with out_a=5.
  - Without the macro: accepted one cycle later with out_a=5.
- Hold out_ready=0 with a bundle valid and keep in_valid=1 -> in_ready=0 and the bundle is unchanged for 5 cycles. Release out_ready -> the next instruction is accepted that cycle.
- Same-cycle wb_en on rd=2 and accept of a new instruction with rd=2 -> pend[2]=1 afterwards and R[2]=wb_data.
- Stream 4 independent instructions with out_ready=1 -> 4 consecutive out_valid cycles with no bubbles.
- Assert rst_n=0 mid-stream with out_valid=1 and pend=4'b0011 -> out_valid=0, pend=0 and R[3]=3 immediately, without waiting for clk.

Source files
------------

// File: rtl/alu_operand_fetch.sv
// Operand-fetch / issue stage in front of the 4-bit ALU: register file, scoreboard, registered bundle.
// Optional same-cycle writeback bypass is enabled by defining ALU_OPF_BYPASS_EN.
module alu_operand_fetch #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_instr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_a,
  output logic [DW-1:0] out_b,
  output logic [1:0]    out_op,
  output logic [1:0]    out_rd,
  input  logic          wb_en,
  input  logic [1:0]    wb_rd,
  input  logic [DW-1:0] wb_data
);

  typedef struct packed {
    logic [1:0] op;
    logic [1:0] rd;
    logic [1:0] rs1;
    logic [1:0] rs2;
  } instr_t;

  instr_t        instr;
  logic [DW-1:0] rf [4];
  logic [3:0]    pend;
  logic [3:0]    pend_next;
  logic [DW-1:0] opnd_a;
  logic [DW-1:0] opnd_b;
  logic          haz_a;
  logic          haz_b;
  logic          hazard;
  logic          accept;

  assign instr = instr_t'(in_instr);

  // NOTE: every always_comb output gets a default first; a path that skips an assignment infers a latch.
  always_comb begin
    opnd_a = rf[instr.rs1];
    opnd_b = rf[instr.rs2];
    haz_a  = pend[instr.rs1];
    haz_b  = pend[instr.rs2];
`ifdef ALU_OPF_BYPASS_EN
    // A result landing this cycle is forwarded and resolves the dependency at once.
    if (wb_en && (wb_rd == instr.rs1)) begin
      opnd_a = wb_data;
      haz_a  = 1'b0;
    end
    if (wb_en && (wb_rd == instr.rs2)) begin
      opnd_b = wb_data;
      haz_b  = 1'b0;
    end
`endif
  end

  assign hazard   = in_valid & (haz_a | haz_b);
  assign in_ready = (~out_valid | out_ready) & ~hazard;
  assign accept   = in_valid & in_ready;

  // Clear first, then set, so a same-index set and clear leaves the bit set.
  always_comb begin
    pend_next = pend;
    if (wb_en)  pend_next[wb_rd]    = 1'b0;
    if (accept) pend_next[instr.rd] = 1'b1;
  end

  // NOTE: the register file is reset because its reset value (R[i] = i) is architecturally visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) rf[i] <= DW'(i);
    end else if (wb_en) begin
      rf[wb_rd] <= wb_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= '0;
    else        pend <= pend_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_op    <= '0;
      out_rd    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_a     <= opnd_a;
      out_b     <= opnd_b;
      out_op    <= instr.op;
      out_rd    <= instr.rd;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
